if_id_stage_buf: RTL and testbench

Parametrised IF/ID pipeline stage with a valid/ready handshake, synchronous flush, bubble insertion and a saturating squash counter. It replaces the fixed-width, always-load IF/ID register between fetch and decode. It carries PC, PC+2 and the instruction word. It can stall fetch without losing an instruction, and it can kill in-flight instructions on a branch redirect.

---
 rtl/if_id_pkg.sv | 17 +
 rtl/if_id_stage_buf.sv | 166 ++++++++++++++++
 tb/tb_if_id_stage_buf.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_pkg.sv
// Shared types and default widths for the IF/ID stage buffer.
// Imported by if_id_stage_buf and its bench.
package if_id_pkg;

    localparam int DEF_PC_W    = 16;
    localparam int DEF_INSTR_W = 16;
    localparam int DEF_CNT_W   = 8;

    localparam logic [15:0] DEF_NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/if_id_stage_buf.sv
// IF/ID stage buffer with valid/ready handshake, flush and squash count.
// IF_ID_SKID_EN adds a skid slot and a registered in_ready.
module if_id_stage_buf
    import if_id_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR =
        INSTR_W'(DEF_NOP_INSTR),
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [PC_W-1:0]    pc_plus2_in,
    input  logic [INSTR_W-1:0] instruction_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pc_out,
    output logic [PC_W-1:0]    pc_plus2_out,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [CNT_W-1:0]   squash_count
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc_plus2;
        logic [INSTR_W-1:0] instr;
    } payload_t;

    state_t         state;
    payload_t       main_q;
    payload_t       in_pl;
    logic           in_fire;
    logic           out_fire;
    logic [2:0]     held;
    logic [2:0]     kill;
    logic [CNT_W:0] cnt_sum;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    assign in_pl = '{
        pc:       pc_in,
        pc_plus2: pc_plus2_in,
        instr:    instruction_in
    };

    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign pc_out          = main_q.pc;
    assign pc_plus2_out    = main_q.pc_plus2;
    assign instruction_out = out_valid ? main_q.instr
                                       : NOP_INSTR;
    assign squash_count    = cnt_q;

    // Entries killed by a flush: held minus the one decode takes,
    // plus anything fetch hands over in the same cycle.
    assign held = (state == FULL) ? 3'd2 :
                  (state == BUSY) ? 3'd1 : 3'd0;
    assign kill = held - {2'b00, out_fire}
                       + {2'b00, in_fire};

    assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(kill);
    assign cnt_nxt = cnt_sum[CNT_W] ? {CNT_W{1'b1}}
                                    : cnt_sum[CNT_W-1:0];

`ifdef IF_ID_SKID_EN

    payload_t skid_q;
    logic     rdy_q;

    assign in_ready = rdy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            main_q <= '{pc: '0, pc_plus2: '0, instr: NOP_INSTR};
            skid_q <= '{pc: '0, pc_plus2: '0, instr: NOP_INSTR};
            rdy_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (flush) begin
            state        <= EMPTY;
            main_q.instr <= NOP_INSTR;
            rdy_q        <= 1'b1;
            cnt_q        <= cnt_nxt;
        end else begin
            rdy_q <= 1'b1;
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_pl;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_pl;
                    end else if (in_fire) begin
                        skid_q <= in_pl;
                        state  <= FULL;
                        rdy_q  <= 1'b0;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= BUSY;
                    end else begin
                        rdy_q <= 1'b0;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`else

    // Holds in_ready low until the first edge after reset release.
    logic live_q;

    assign in_ready = live_q && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            main_q <= '{pc: '0, pc_plus2: '0, instr: NOP_INSTR};
            live_q <= 1'b0;
            cnt_q  <= '0;
        end else if (flush) begin
            state        <= EMPTY;
            main_q.instr <= NOP_INSTR;
            live_q       <= 1'b1;
            cnt_q        <= cnt_nxt;
        end else begin
            live_q <= 1'b1;
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_pl;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (out_fire) begin
                        if (in_fire)
                            main_q <= in_pl;
                        else
                            state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_if_id_stage_buf.sv
// Scoreboard bench for if_id_stage_buf (either skid build).
// Squash counter is built 2 bits wide to reach saturation.
module tb_if_id_stage_buf;

    localparam int CW = 2;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] p2;
        logic [15:0] ins;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [15:0]   pc_in = '0;
    logic [15:0]   pc_plus2_in = '0;
    logic [15:0]   instruction_in = '0;
    logic          in_ready;
    logic          out_valid;
    logic [15:0]   pc_out;
    logic [15:0]   pc_plus2_out;
    logic [15:0]   instruction_out;
    logic [CW-1:0] squash_count;

    ent_t q[$];
    ent_t src[$];
    int   sq = 0;
    bit   live = 0;
    int   total = 0;
    int   bad = 0;

    if_id_stage_buf #(
        .PC_W(16),
        .INSTR_W(16),
        .NOP_INSTR(16'h0000),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pc_in(pc_in),
        .pc_plus2_in(pc_plus2_in),
        .instruction_in(instruction_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pc_out(pc_out),
        .pc_plus2_out(pc_plus2_out),
        .instruction_out(instruction_out),
        .squash_count(squash_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] pc,
                        input logic [15:0] ins);
        ent_t e;
        e.pc  = pc;
        e.p2  = pc + 16'd2;
        e.ins = ins;
        src.push_back(e);
    endtask

    // One clock: drive, check against the model, then advance.
    task automatic cycle(input bit rdy, input bit fl);
        bit er;
        bit ofire;
        bit ifire;
        int kill;
        in_valid = (src.size() != 0);
        if (in_valid) begin
            pc_in          = src[0].pc;
            pc_plus2_in    = src[0].p2;
            instruction_in = src[0].ins;
        end else begin
            pc_in          = 16'($urandom);
            pc_plus2_in    = 16'($urandom);
            instruction_in = 16'($urandom);
        end
        out_ready = rdy;
        flush     = fl;
        #1;
`ifdef IF_ID_SKID_EN
        er = live && (q.size() < 2);
`else
        er = live && (q.size() == 0 || rdy);
`endif
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("pc_out", 32'(pc_out), 32'(q[0].pc));
            chk("pc_plus2", 32'(pc_plus2_out), 32'(q[0].p2));
            chk("instr", 32'(instruction_out), 32'(q[0].ins));
        end else begin
            chk("nop", 32'(instruction_out), 32'h0);
        end
        chk("squash", 32'(squash_count), 32'(sq));
        ofire = (q.size() != 0) && rdy;
        ifire = in_valid && er;
        if (fl) begin
            kill = q.size() - int'(ofire) + int'(ifire);
            sq = (sq + kill > 3) ? 3 : sq + kill;
            q.delete();
            if (ifire) src.delete(0);
        end else begin
            if (ofire) q.delete(0);
            if (ifire) begin
                q.push_back(src[0]);
                src.delete(0);
            end
        end
        @(posedge clk);
        live = 1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic async_reset(input bit check);
        in_valid = 1'b0;
        flush    = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        if (check) begin
            chk("rst_valid", 32'(out_valid), 32'h0);
            chk("rst_instr", 32'(instruction_out), 32'h0);
            chk("rst_squash", 32'(squash_count), 32'h0);
            chk("rst_ready", 32'(in_ready), 32'h0);
        end
        q.delete();
        src.delete();
        sq   = 0;
        live = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #3;
        chk("init_valid", 32'(out_valid), 32'h0);
        chk("init_ready", 32'(in_ready), 32'h0);
        chk("init_pc", 32'(pc_out), 32'h0);
        chk("init_pc2", 32'(pc_plus2_out), 32'h0);
        chk("init_instr", 32'(instruction_out), 32'h0);
        chk("init_squash", 32'(squash_count), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cycle(1, 0);

        // back-to-back stream
        push(16'h0004, 16'h1234);
        push(16'h0008, 16'h5678);
        repeat (4) cycle(1, 0);

        // backpressure then drain
        push(16'h0010, 16'h1234);
        push(16'h0014, 16'h5678);
        push(16'h0018, 16'h9ABC);
        repeat (4) cycle(0, 0);
        repeat (5) cycle(1, 0);

        // flush while stalled with fetch still offering
        async_reset(0);
        cycle(1, 0);
        push(16'h0020, 16'h1111);
        push(16'h0022, 16'h2222);
        push(16'h0024, 16'h3333);
        repeat (3) cycle(0, 0);
        cycle(0, 1);
        src.delete();
        cycle(1, 0);

        // flush while busy, input and output both firing
        async_reset(0);
        cycle(1, 0);
        push(16'h0030, 16'hAAAA);
        cycle(1, 0);
        push(16'h0032, 16'hBBBB);
        cycle(1, 1);
        cycle(1, 0);

        // counter saturation
        for (int i = 0; i < 5; i++) begin
            push(16'(16'h0040 + 2 * i), 16'(16'hC000 + i));
            cycle(0, 0);
            cycle(0, 1);
        end
        cycle(1, 0);

        // reset mid-stream with non-zero count
        push(16'h0050, 16'hD000);
        cycle(0, 0);
        push(16'h0052, 16'hD001);
        push(16'h0054, 16'hD002);
        push(16'h0056, 16'hD003);
        repeat (3) cycle(0, 0);
        async_reset(1);
        cycle(1, 0);
        cycle(1, 0);

        // random mix
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0 && src.size() < 4)
                push(16'($urandom), 16'($urandom));
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
        end
        src.delete();
        repeat (4) cycle(1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
